// File: rtl/if_unit.sv
// Instruction-fetch stage for the SimpleRisc pipeline: holds the PC and a word-addressed
// instruction memory, and drives the IF/OF pipeline latch consumed by of_unit.
module if_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN   = 32'h6800_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch_taken,
    input  logic [31:0] branch_pc,
    input  logic        prog_we,
    input  logic [31:0] prog_adr,
    input  logic [31:0] prog_data,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic [31:0] fetch_pc
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    logic [31:0] pcOut_q, pcOut_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [IDX_W-1:0] fetchIdx;
    logic [IDX_W-1:0] progIdx;

    assign fetchIdx = pc_q[IDX_W+1:2];
    assign progIdx  = prog_adr[IDX_W+1:2];

    // Program writes are independent of reset, redirect and hold; memory is never cleared.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            imem[progIdx] <= prog_data;
        end
    end

    // Redirect beats hold; a write forces hold, so a fetch never sees a same-cycle write.
    always_comb begin
        pc_d    = pc_q;
        pcOut_d = pcOut_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (is_branch_taken) begin
            pc_d    = {branch_pc[31:2], 2'b00};
            pcOut_d = pc_q;
            instr_d = NOP_INSN;
            valid_d = 1'b0;
        end else if (!(stall || prog_we)) begin
            pc_d    = pc_q + 32'd4;
            pcOut_d = pc_q;
            instr_d = imem[fetchIdx];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            pcOut_q <= 32'h0000_0000;
            instr_q <= NOP_INSN;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pcOut_q <= pcOut_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out          = pcOut_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;
    assign fetch_pc        = pc_q;

    // Address bits outside the word index are intentionally ignored.
    logic unusedBits;
    assign unusedBits = ^{branch_pc[1:0], prog_adr[31:IDX_W+2], prog_adr[1:0]};

endmodule

// File: tb/tb_if_unit.sv
// Self-checking bench for if_unit: a behavioural fetch model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_if_unit;

    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        is_branch_taken = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        prog_we = 1'b0;
    logic [31:0] prog_adr = '0;
    logic [31:0] prog_data = '0;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetch_pc;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    logic [31:0] mPc, mPcOut, mInstr;
    logic        mValid;
    logic [31:0] mMem [256];

    if_unit #(.IMEM_DEPTH(256), .RESET_PC(32'h0), .NOP_INSN(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .is_branch_taken(is_branch_taken),
        .branch_pc(branch_pc), .prog_we(prog_we), .prog_adr(prog_adr), .prog_data(prog_data),
        .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out),
        .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model by the rules.
    task automatic applyStimulus(input logic rst, input logic st, input logic br,
                                 input logic [31:0] bpc, input logic we,
                                 input logic [31:0] adr, input logic [31:0] data);
        reset = rst; stall = st; is_branch_taken = br; branch_pc = bpc;
        prog_we = we; prog_adr = adr; prog_data = data;
        @(posedge clk);
        if (!rst) begin
            mPc = 32'h0; mPcOut = 32'h0; mInstr = NOP; mValid = 1'b0;
        end else if (br) begin
            mPcOut = mPc; mPc = (bpc / 4) * 4; mInstr = NOP; mValid = 1'b0;
        end else if (!st && !we) begin
            mPcOut = mPc; mInstr = mMem[(mPc / 4) % 256]; mValid = 1'b1; mPc = mPc + 4;
        end
        if (we) mMem[(adr / 4) % 256] = data;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expectLatch(input string name, input logic [31:0] pc, input logic [31:0] insn,
                               input logic v, input logic [31:0] fpc);
        checkOutput({name, ".pc_out"}, pc_out, pc);
        checkOutput({name, ".insn"}, instruction_out, insn);
        checkOutput({name, ".valid"}, {31'h0, valid_out}, {31'h0, v});
        checkOutput({name, ".fetch_pc"}, fetch_pc, fpc);
    endtask

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("model.pc_out", pc_out, mPcOut);
            checkOutput("model.insn", instruction_out, mInstr);
            checkOutput("model.valid", {31'h0, valid_out}, {31'h0, mValid});
            checkOutput("model.fetch_pc", fetch_pc, mPc);
        end
    end

    initial begin
        logic [31:0] loadData [12];
        loadData = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                     32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888,
                     32'h0000_0009, 32'h0000_000A, 32'h0000_000B, 32'h0000_000C};

        // Program load happens while reset is held low.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), loadData[i]);
            compareOn = 1'b1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_03FC, 32'hFFFF_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        expectLatch("reset", 32'h0, NOP, 1'b0, 32'h0);

        // Load and stream
        run(1); expectLatch("stream0", 32'h0, 32'h1111_1111, 1'b1, 32'h4);
        run(1); expectLatch("stream1", 32'h4, 32'h2222_2222, 1'b1, 32'h8);
        run(1); expectLatch("stream2", 32'h8, 32'h3333_3333, 1'b1, 32'hC);

        // Stall for three edges, then resume without losing an instruction
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            expectLatch("stall", 32'h8, 32'h3333_3333, 1'b1, 32'hC);
        end
        run(1); expectLatch("stream3", 32'hC, 32'h4444_4444, 1'b1, 32'h10);

        // Back to 0 so fetch_pc reaches 8, then branch flush to 0x13
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        expectLatch("redir0", 32'h10, NOP, 1'b0, 32'h0);
        run(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 32'h0);
        expectLatch("flush", 32'h8, NOP, 1'b0, 32'h10);
        run(1); expectLatch("target", 32'h10, 32'h5555_5555, 1'b1, 32'h14);

        // Branch beats stall
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        expectLatch("brStall", 32'h14, NOP, 1'b0, 32'h4);
        run(1); expectLatch("brStallNext", 32'h4, 32'h2222_2222, 1'b1, 32'h8);

        // A write holds the pipe; a redirect with a write still redirects and writes
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 32'h9999_0000);
        expectLatch("weHold", 32'h4, 32'h2222_2222, 1'b1, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'h28, 32'hAAAA_AAAA);
        expectLatch("brWe", 32'h8, NOP, 1'b0, 32'h24);
        run(1); expectLatch("newWord9", 32'h24, 32'h9999_0000, 1'b1, 32'h28);
        run(1); expectLatch("newWord10", 32'h28, 32'hAAAA_AAAA, 1'b1, 32'h2C);

        // Memory index wraps modulo 1 KiB
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h0);
        run(1); expectLatch("wrap", 32'h400, 32'h1111_1111, 1'b1, 32'h404);
        run(1);

        // Mid-run reset overrides redirect and stall; memory survives
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        expectLatch("midReset", 32'h0, NOP, 1'b0, 32'h0);
        run(1); expectLatch("restart", 32'h0, 32'h1111_1111, 1'b1, 32'h4);

        // 32-bit PC wrap
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
        run(1); expectLatch("pcWrap", 32'hFFFF_FFFC, 32'hFFFF_0000, 1'b1, 32'h0);

        // Mixed traffic kept inside the loaded region, checked by the model
        for (int i = 0; i < 60; i++) begin
            logic rst, st, br;
            logic [31:0] bpc;
            rst = ($urandom_range(0, 19) != 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ((mPc / 4) % 256 > 9) || ($urandom_range(0, 7) == 0);
            bpc = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            applyStimulus(rst, st, br, bpc, 1'b0, 32'h0, 32'h0);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_unit.md
# if_unit

Instruction-fetch stage of the five-stage SimpleRisc pipeline. It sits directly upstream of `of_unit`. It holds the architectural PC and a word-addressed instruction memory, and drives the IF/OF pipeline latch (`pc_out`, `instruction_out`, `valid_out`) that `of_unit` consumes as `pc_in` and `instruction_in`. It also provides:
- stall from the hazard unit,
- branch redirect/flush from the execute stage,
- a program-load write port for the testbench and bring-up.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction-memory depth in 32-bit words; power of two.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word-aligned.
- `NOP_INSN`, 32'h6800_0000: SimpleRisc `nop` encoding, injected on reset and flush.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-low reset. Sampled on the rising edge of `clk`; 0 = reset.
- `stall`  in  1: hold PC and IF/OF latch.
- `is_branch_taken`  in  1: redirect request from execute stage.
- `branch_pc`  in  32: redirect target; bits [1:0] ignored.
- `prog_we`  in  1: instruction-memory write enable.
- `prog_adr`  in  32: byte address for write; word index = `prog_adr[log2(IMEM_DEPTH)+1:2]`.
- `prog_data`  in  32: write data.
- `pc_out`  out  32: PC of the instruction in the latch; feeds `of_unit.pc_in`.
- `instruction_out`  out  32: latched instruction; feeds `of_unit.instruction_in`.
- `valid_out`  out  1: latch holds a real fetched instruction; 0 for a bubble.
- `fetch_pc`  out  32: current internal PC (the next address to be fetched); for debug and branch-predict hooks.

## Operation
- State:
  - `pc` register;
  - `imem[IMEM_DEPTH]` array;
  - IF/OF latch (`pc_out`, `instruction_out`, `valid_out`).
- Memory index: `pc[log2(IMEM_DEPTH)+1:2]`. Upper PC bits are ignored, so addresses wrap modulo `IMEM_DEPTH*4`. The PC itself is a full 32-bit value that wraps 32'hFFFF_FFFC -> 0.
- Each cycle, exactly one of the following applies, in priority order:
  1. Reset (`reset`=0):
     - `pc` <= `RESET_PC`, `pc_out` <= 0, `instruction_out` <= `NOP_INSN`, `valid_out` <= 0.
     - `imem` contents are not cleared.
     - `prog_we` is still honoured during reset.
  2. Redirect (`is_branch_taken`=1, regardless of `stall` and `prog_we`):
     - `pc` <= {`branch_pc[31:2]`, 2'b00}.
     - Latch flushed: `instruction_out` <= `NOP_INSN`, `valid_out` <= 0, `pc_out` <= old `pc`.
  3. Hold (`stall`=1 or `prog_we`=1): `pc` and the latch keep their values.
  4. Fetch: `pc_out` <= `pc`, `instruction_out` <= `imem[index(pc)]`, `valid_out` <= 1, `pc` <= `pc`+4.
- Program write: when `prog_we`=1, `imem[index(prog_adr)]` <= `prog_data` on the edge. This happens independently of rules 1–4 above.
- Same-cycle write and fetch of the same word is not possible, because a write forces hold. A redirect in the same cycle as a write does not read memory.
- `fetch_pc` = `pc` (combinational from the register).

## Timing
- Reset values: `pc_out`=0, `instruction_out`=`NOP_INSN`, `valid_out`=0, `fetch_pc`=`RESET_PC`.
- First edge after `reset` deasserts: latch gets `imem[RESET_PC]`, `valid_out`=1, `fetch_pc`=`RESET_PC`+4.
- Latency: the instruction at PC p appears on `instruction_out` one edge after `fetch_pc`=p. Throughput is 1 instruction per cycle when there is no stall.
- Redirect: one bubble (`valid_out`=0) on the edge where `is_branch_taken` is sampled. The target instruction is latched on the following edge, provided there is no stall.
- Stall of N cycles: latch and `fetch_pc` are frozen for N edges. Fetch resumes on the first edge with `stall`=0. No instruction is lost or duplicated.
- Reset asserted mid-stream: takes effect on that edge and overrides redirect and stall.
- `prog_we` held continuously: the pipeline is frozen until it is released.

## Test plan
- Load & stream:
  - Stimulus: write `imem[0..3]` = 32'h1111_1111..32'h4444_4444 via `prog_we`, then release reset with `RESET_PC`=0.
  - Required response: on 4 consecutive edges, (`pc_out`,`instruction_out`) = (0,1111_1111), (4,2222_2222), (8,3333_3333), (C,4444_4444), with `valid_out`=1 throughout.
- Stall:
  - Stimulus: assert `stall` for 3 cycles while the latch holds (8,3333_3333).
  - Required response: latch and `fetch_pc`=C are unchanged for 3 edges; the next edge gives (C,4444_4444).
- Branch flush:
  - Stimulus: `is_branch_taken`=1 with `branch_pc`=32'h0000_0013 while `fetch_pc`=8.
  - Required response: next edge gives `instruction_out`=6800_0000, `valid_out`=0, `fetch_pc`=10; the following edge gives (10,`imem[4]`).
- Branch beats stall:
  - Stimulus: `stall`=1 and `is_branch_taken`=1 with `branch_pc`=4 in the same cycle.
  - Required response: `fetch_pc`=4 and a bubble in the latch.
- Wrap:
  - Stimulus: with `IMEM_DEPTH`=256, redirect to 32'h0000_0400.
  - Required response: fetches `imem[0]` with `pc_out`=400.
- Reset mid-run:
  - Stimulus: drive `reset`=0 for 1 edge during streaming.
  - Required response: `pc_out`=0, NOP, `valid_out`=0, `fetch_pc`=0; memory contents preserved, so streaming restarts at `imem[0]`.
